// File: rtl/draw_pkg.sv
// Shared types and constants for the frame-sequencing control path.
// Holds the FSM state encoding, screen geometry and the lives width.
package draw_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ERASE     = 3'd1,
    S_UPDATE    = 3'd2,
    S_DRAW      = 3'd3,
    S_WAIT      = 3'd4,
    S_OVER_DRAW = 3'd5,
    S_OVER_HOLD = 3'd6
  } state_t;

  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int SCREEN_PIXELS = 19200;

  localparam logic [2:0] BLACK = 3'b000;

  localparam int LIVES_W = 2;

endpackage

// File: rtl/frame_tick_counter.sv
// Frame tick divider: counts 0..FRAME_TICKS-1 while en, pulses tick on the wrap.
// Latency: tick is combinational off the count; clears to 0 whenever en is low.
// Backpressure: none; with DRAW_CONTROL_PAUSE_EN, hold freezes the count and masks tick.
module frame_tick_counter
  import draw_pkg::*;
#(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
`ifdef DRAW_CONTROL_PAUSE_EN
  input  logic hold,
`endif
  output logic tick
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] count;
  logic          run;

`ifdef DRAW_CONTROL_PAUSE_EN
  assign run = en & ~hold;
`else
  assign run = en;
`endif

  assign tick = run && (count == LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/draw_control.sv
// Frame sequencer erase->update->draw->wait with lives counting and game-over hold.
// Latency: Moore ld_* outputs; plot is the ld OR delayed one cycle. Optional pause via DRAW_CONTROL_PAUSE_EN.
// Backpressure: each streamer phase holds its ld until the matching done is sampled.
module draw_control
  import draw_pkg::*;
#(
  parameter int FRAME_TICKS     = 833333,
  parameter int FRAMES_PER_STEP = 4,
  parameter int LIVES           = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               miss,
  input  logic               done_erase,
  input  logic               done_draw,
  input  logic               done_over,
`ifdef DRAW_CONTROL_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ld_erase,
  output logic               ld_update,
  output logic               ld_draw,
  output logic               ld_game_over,
  output logic               plot,
  output logic [LIVES_W-1:0] lives_left,
  output logic               game_over
);

  localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(FRAMES_PER_STEP - 1);

  state_t        state, state_nxt;
  logic          start_q;
  logic          start_edge;
  logic          tick;
  logic          paused;
  logic          miss_ok;
  logic [SW-1:0] step;

  assign start_edge = start & ~start_q;

`ifdef DRAW_CONTROL_PAUSE_EN
  assign paused = pause && (state == S_WAIT);
`else
  assign paused = 1'b0;
`endif

  assign miss_ok = miss && !paused &&
                   ((state == S_ERASE) || (state == S_UPDATE) ||
                    (state == S_DRAW)  || (state == S_WAIT));

  frame_tick_counter #(
    .FRAME_TICKS(FRAME_TICKS)
  ) u_frame_tick (
    .clk   (clk),
    .resetn(resetn),
    .en    (state == S_WAIT),
`ifdef DRAW_CONTROL_PAUSE_EN
    .hold  (pause),
`endif
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_erase     = 1'b0;
    ld_update    = 1'b0;
    ld_draw      = 1'b0;
    ld_game_over = 1'b0;
    game_over    = 1'b0;
    case (state)
      S_IDLE: if (start_edge) state_nxt = S_ERASE;
      S_ERASE: begin
        ld_erase = 1'b1;
        if (done_erase) state_nxt = S_UPDATE;
      end
      // Branch on the registered lives: a miss in this same cycle only lands next frame.
      S_UPDATE: begin
        ld_update = 1'b1;
        state_nxt = (lives_left == '0) ? S_OVER_DRAW : S_DRAW;
      end
      S_DRAW: begin
        ld_draw = 1'b1;
        if (done_draw) state_nxt = S_WAIT;
      end
      S_WAIT: if (tick && (step == LAST_STEP)) state_nxt = S_ERASE;
      S_OVER_DRAW: begin
        ld_game_over = 1'b1;
        game_over    = 1'b1;
        if (done_over) state_nxt = S_OVER_HOLD;
      end
      S_OVER_HOLD: begin
        game_over = 1'b1;
        if (start_edge) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q    <= 1'b0;
      plot       <= 1'b0;
      step       <= '0;
      lives_left <= LIVES_W'(LIVES);
    end else begin
      start_q <= start;
      plot    <= ld_erase | ld_draw | ld_game_over;

      if (state != S_WAIT) step <= '0;
      else if (tick)       step <= (step == LAST_STEP) ? '0 : step + SW'(1);

      if ((state == S_IDLE) && start_edge)     lives_left <= LIVES_W'(LIVES);
      else if (miss_ok && (lives_left != '0))  lives_left <= lives_left - LIVES_W'(1);
    end
  end

endmodule

// File: tb/tb_draw_control.sv
// Scoreboard bench for draw_control: an event-level model queues expected ld phases,
// a monitor pops and compares them as the DUT raises and drops each ld.
`timescale 1ns/1ps
module tb_draw_control;
  import draw_pkg::*;

  localparam int FT  = 10;
  localparam int FPS = 2;
  localparam int NL  = 3;

  localparam int K_ERASE = 0, K_UPDATE = 1, K_DRAW = 2, K_OVER = 3, K_WAIT = 4;

  typedef struct {
    int kind;
    int lives;
    int len;
  } ev_t;

  ev_t exp_q[$];

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, miss = 1'b0;
  logic done_erase = 1'b0, done_draw = 1'b0, done_over = 1'b0;
`ifdef DRAW_CONTROL_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic ld_erase, ld_update, ld_draw, ld_game_over, plot, game_over;
  logic [LIVES_W-1:0] lives_left;

  int n_checks = 0;
  int n_fails  = 0;
  int model_lives;

  always #5 clk = ~clk;

  draw_control #(
    .FRAME_TICKS(FT), .FRAMES_PER_STEP(FPS), .LIVES(NL)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .miss(miss),
    .done_erase(done_erase), .done_draw(done_draw), .done_over(done_over),
`ifdef DRAW_CONTROL_PAUSE_EN
    .pause(pause),
`endif
    .ld_erase(ld_erase), .ld_update(ld_update), .ld_draw(ld_draw),
    .ld_game_over(ld_game_over), .plot(plot), .lives_left(lives_left),
    .game_over(game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int dec(input int l);
    return (l > 0) ? l - 1 : 0;
  endfunction

  function automatic logic ld_of(input int k);
    case (k)
      K_ERASE:  return ld_erase;
      K_UPDATE: return ld_update;
      K_DRAW:   return ld_draw;
      default:  return ld_game_over;
    endcase
  endfunction

  task automatic push_ev(input int kind, input int lives, input int len);
    ev_t e;
    e.kind = kind; e.lives = lives; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic clear_pulses();
    done_erase = 1'b0; done_draw = 1'b0; done_over = 1'b0;
    miss = 1'b0; start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_pulses();
    end
  endtask

  task automatic wait_ld(input int k, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      clear_pulses();
      seen = ld_of(k);
    end
    if (!seen) begin
      n_checks++; n_fails++;
      $display("FAIL wait_ld kind%0d: not raised within %0d cycles", k, limit);
    end
  endtask

  // Ld is seen high on sample 1; done is driven on sample d so ld stays high d cycles.
  task automatic drive_active(input int k, input int d, input bit m);
    wait_ld(k, 300);
    if (m) miss = 1'b1;
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      miss = 1'b0;
    end
    case (k)
      K_ERASE: done_erase = 1'b1;
      K_DRAW:  done_draw  = 1'b1;
      default: done_over  = 1'b1;
    endcase
  endtask

  // mp: miss phase 0 none, 1 erase, 2 update, 3 draw (or game-over), 4 wait.
  task automatic run_frame(input int de, input int dd, input int mp, input bit pz, output bit over);
    int lu;
    push_ev(K_ERASE, model_lives, de);
    if (mp == 1) model_lives = dec(model_lives);
    push_ev(K_UPDATE, model_lives, 1);
    lu = model_lives;
    if (mp == 2) model_lives = dec(model_lives);
    over = (lu == 0);
    if (over) begin
      push_ev(K_OVER, model_lives, SCREEN_PIXELS);
    end else begin
      push_ev(K_DRAW, model_lives, dd);
      if (mp == 3) model_lives = dec(model_lives);
      push_ev(K_WAIT, model_lives, FT * FPS + (pz ? 30 : 0));
      if (mp == 4 && !pz) model_lives = dec(model_lives);
    end

    drive_active(K_ERASE, de, mp == 1);
    wait_ld(K_UPDATE, 4);
    if (mp == 2) miss = 1'b1;
    if (over) begin
      drive_active(K_OVER, SCREEN_PIXELS, mp >= 3);
    end else begin
      drive_active(K_DRAW, dd, mp == 3);
      if (pz) begin
`ifdef DRAW_CONTROL_PAUSE_EN
        wait_cycles(3);
        pause = 1'b1;
        wait_cycles(15);
        miss = 1'b1;
        wait_cycles(15);
        pause = 1'b0;
`endif
      end else if (mp == 4) begin
        wait_cycles($urandom_range(1, 15));
        miss = 1'b1;
      end
    end
  endtask

  task automatic pop_cmp(input int kind, input int lives, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fails++;
      $display("FAIL unexpected_event: got kind%0d, expected no event", kind);
      return;
    end
    e = exp_q.pop_front();
    check($sformatf("event_kind(exp kind%0d)", e.kind), kind, e.kind);
    check($sformatf("kind%0d_lives", e.kind), lives, e.lives);
    check($sformatf("kind%0d_length", e.kind), len, e.len);
  endtask

  initial begin : monitor
    logic [3:0] prv, cur;
    int rise_cyc[4];
    int rise_lv[4];
    bit gap_on;
    int gap_cnt, gap_lv, cyc;
    logic prev_or;
    prv = '0; prev_or = 1'b0; gap_on = 1'b0; gap_cnt = 0; gap_lv = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        prv = '0; prev_or = 1'b0; gap_on = 1'b0;
        continue;
      end
      check("plot_delayed_or", plot, prev_or);
      cur = {ld_game_over, ld_draw, ld_update, ld_erase};
      for (int k = 0; k < 4; k++) begin
        if (cur[k] && !prv[k]) begin
          rise_cyc[k] = cyc;
          rise_lv[k]  = int'(lives_left);
          if (k == K_ERASE && gap_on) begin
            pop_cmp(K_WAIT, gap_lv, gap_cnt);
            gap_on = 1'b0;
          end
        end
        if (!cur[k] && prv[k]) begin
          pop_cmp(k, rise_lv[k], cyc - rise_cyc[k]);
          if (k == K_DRAW) begin
            gap_on = 1'b1;
            gap_cnt = 0;
          end
        end
      end
      if (gap_on && cur == 4'b0) begin
        if (gap_cnt == 0) gap_lv = int'(lives_left);
        gap_cnt++;
      end
      prv = cur;
      prev_or = ld_erase | ld_draw | ld_game_over;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit ov;
    ov = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_ld", {ld_erase, ld_update, ld_draw, ld_game_over}, 0);
    check("reset_plot", plot, 0);
    check("reset_game_over", game_over, 0);
    check("reset_lives", lives_left, NL);
    resetn = 1'b1;
    wait_cycles(3);
    check("idle_no_ld", {ld_erase, ld_update, ld_draw, ld_game_over}, 0);

    start = 1'b1;
    model_lives = NL;
    run_frame(5, 5, 0, 1'b0, ov);

`ifdef DRAW_CONTROL_PAUSE_EN
    run_frame($urandom_range(1, 8), $urandom_range(1, 8), 0, 1'b1, ov);
`endif

    for (int f = 0; f < 40 && !ov; f++)
      run_frame($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 4), 1'b0, ov);
    check("game_over_reached", ov, 1);

    @(negedge clk);
    clear_pulses();
    check("over_ld_fell", ld_game_over, 0);
    check("over_plot_lags", plot, 1);
    check("over_flag_held", game_over, 1);
    miss = 1'b1;
    @(negedge clk);
    clear_pulses();
    check("over_plot_fell", plot, 0);
    check("over_flag_hold", game_over, 1);
    wait_cycles(2);
    check("over_lives_zero", lives_left, 0);

    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_start_single_transition", {game_over, ld_erase, ld_update}, 0);
    end
    start = 1'b0;
    wait_cycles(2);
    check("idle_lives_not_reloaded", lives_left, 0);

    start = 1'b1;
    model_lives = NL;
    push_ev(K_ERASE, NL, 4);
    push_ev(K_UPDATE, NL - 1, 1);
    drive_active(K_ERASE, 4, 1'b1);
    wait_ld(K_UPDATE, 4);
    wait_ld(K_DRAW, 4);
    wait_cycles(2);
    check("restart_lives_after_miss", lives_left, NL - 1);
    exp_q.delete();
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_reset_ld", {ld_erase, ld_update, ld_draw, ld_game_over}, 0);
    check("async_reset_plot", plot, 0);
    check("async_reset_game_over", game_over, 0);
    check("async_reset_lives", lives_left, NL);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_cycles(2);

    start = 1'b1;
    model_lives = NL;
    run_frame($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 4), 1'b0, ov);
    wait_ld(K_ERASE, 200);
    wait_cycles(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
